spectrum_analyser_sequencer: RTL

Parametrised multi-channel control sequencer for the spectrum analyser datapath. It steps through a masked set of input channels. For each channel it launches N back-to-back FFT frames for averaging, then one graph render. It supports single-sweep and continuous modes, abort, and a watchdog timeout. It sits above the FFT core and graph renderer and drives the channel-select and datapath mux controls.

---
 rtl/spectrum_analyser_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spectrum_analyser_sequencer.sv
// Multi-channel sequencer: per masked channel, N averaged FFT frames then one graph render.
// Single-sweep or continuous, with abort and a wait-state watchdog.
module spectrum_analyser_sequencer #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned AVG_W  = 4,
   parameter int unsigned WDOG_W = 16,
   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_start,
   input  logic              i_continuous,
   input  logic              i_abort,
   input  logic [N_CH-1:0]   i_ch_mask,
   input  logic [AVG_W-1:0]  i_avg_frames,
   input  logic              i_fft_done,
   input  logic              i_graph_done,
   output logic              o_fft_start,
   output logic              o_graph_start,
   output logic [CH_W-1:0]   o_ch,
   output logic              o_fft_active,
   output logic              o_graph_active,
   output logic              o_busy,
   output logic [AVG_W-1:0]  o_frame_idx,
   output logic              o_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FFT_START,
      S_FFT_WAIT,
      S_GRAPH_START,
      S_GRAPH_WAIT
   } state_t;

   state_t             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [AVG_W-1:0]   frame_q, frame_d;
   logic [AVG_W-1:0]   avg_q, avg_d;
   logic [N_CH-1:0]    mask_q, mask_d;
   logic [WDOG_W-1:0]  wdog_q, wdog_d;
   logic               timeout_q, timeout_d;

   logic [AVG_W-1:0]   frame_inc;
   logic [WDOG_W-1:0]  wdog_inc;
   logic               nxt_found;
   logic [CH_W-1:0]    nxt_ch;

   function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int unsigned i = N_CH; i > 0; i--) begin
         if (m[CH_W'(i - 1)]) idx = CH_W'(i - 1);
      end
      return idx;
   endfunction

   // Descending scan so the last hit is the nearest set bit above the current channel.
   always_comb begin
      nxt_found = 1'b0;
      nxt_ch    = '0;
      for (int unsigned i = N_CH; i > 0; i--) begin
         if (mask_q[CH_W'(i - 1)] && ((i - 1) > int'(ch_q))) begin
            nxt_found = 1'b1;
            nxt_ch    = CH_W'(i - 1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      frame_d   = frame_q;
      avg_d     = avg_q;
      mask_d    = mask_q;
      wdog_d    = wdog_q;
      timeout_d = timeout_q;
      frame_inc = (frame_q == '1) ? frame_q : frame_q + AVG_W'(1);
      wdog_inc  = wdog_q + WDOG_W'(1);
      if (i_en) begin
         if (i_abort) begin
            state_d = S_IDLE;
            wdog_d  = '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (i_start && (i_ch_mask != '0)) begin
                     mask_d    = i_ch_mask;
                     avg_d     = (i_avg_frames == '0) ? AVG_W'(1) : i_avg_frames;
                     ch_d      = lowest_set(i_ch_mask);
                     frame_d   = '0;
                     timeout_d = 1'b0;
                     state_d   = S_FFT_START;
                  end
               end
               S_FFT_START: begin
                  wdog_d  = '0;
                  state_d = S_FFT_WAIT;
               end
               S_FFT_WAIT: begin
                  if (i_fft_done) begin
                     frame_d = frame_inc;
                     state_d = (frame_inc < avg_q) ? S_FFT_START : S_GRAPH_START;
                  end else begin
                     wdog_d = wdog_inc;
                     if (wdog_inc == '1) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                     end
                  end
               end
               S_GRAPH_START: begin
                  wdog_d  = '0;
                  state_d = S_GRAPH_WAIT;
               end
               S_GRAPH_WAIT: begin
                  if (i_graph_done) begin
                     if (nxt_found) begin
                        ch_d    = nxt_ch;
                        frame_d = '0;
                        state_d = S_FFT_START;
                     end else if (i_continuous) begin
                        ch_d    = lowest_set(mask_q);
                        frame_d = '0;
                        state_d = S_FFT_START;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end else begin
                     wdog_d = wdog_inc;
                     if (wdog_inc == '1) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                     end
                  end
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         ch_q      <= '0;
         frame_q   <= '0;
         avg_q     <= '0;
         mask_q    <= '0;
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         frame_q   <= frame_d;
         avg_q     <= avg_d;
         mask_q    <= mask_d;
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_fft_start    = (state_q == S_FFT_START);
   assign o_graph_start  = (state_q == S_GRAPH_START);
   assign o_fft_active   = (state_q == S_FFT_START) || (state_q == S_FFT_WAIT);
   assign o_graph_active = (state_q == S_GRAPH_START) || (state_q == S_GRAPH_WAIT);
   assign o_busy         = (state_q != S_IDLE);
   assign o_ch           = ch_q;
   assign o_frame_idx    = frame_q;
   assign o_timeout      = timeout_q;

endmodule
